lsu_rmw_ctrl: RTL and testbench
===============================

// Module: lsu_rmw_ctrl
// PURPOSE
//  Load/store unit between rv32i_core data port and a word-only synchronous data RAM.
//  Accepts one byte/half/word load or store per handshake and performs sign/zero extension.
//  Partial stores are done as read-modify-write.
//  Flags misaligned or illegal-size requests without touching memory.
// PARAMETERS
//  ADDR_W   7   byte-address width (RAM depth = 2**(ADDR_W-2) words)
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous active-high reset
//  req_valid  in   1         core request valid
//  req_ready  out  1         unit can accept request (IDLE only)
//  req_we     in   1         1=store, 0=load
//  req_size   in   3         funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   32        store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1         one-cycle response pulse
//  rsp_rdata  out  32        extended load data; 0 for stores and errors
//  rsp_err    out  1         misaligned or illegal size; valid with rsp_valid
//  mem_en     out  1         RAM access enable
//  mem_we     out  1         RAM write enable (whole word)
//  mem_addr   out  ADDR_W-2  RAM word address
//  mem_wdata  out  32        RAM write word
//  mem_rdata  in   32        RAM read word, valid exactly 1 cycle after read access
// BEHAVIOUR
//  Clock/reset: one clock. Reset is synchronous and active-high.
//  Reset: state=IDLE, latched request=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0.
//  Reset mid-operation aborts the access. No write is issued after the reset edge.
//  Handshake: accept when req_valid & req_ready; req_ready=1 iff state==IDLE. Request fields latched on accept.
//  Error check at accept:
//   - Illegal size: 011, 110, 111, or a store with size 100/101.
//   - Misaligned: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
//  FSM states: IDLE, RD, WAIT, WR, RSP.
//   - IDLE -> RSP with err=1 if the request fails the error check.
//   - IDLE -> WR for SW.
//   - IDLE -> RD for every other legal request.
//   - RD: mem_en=1, mem_we=0, mem_addr=addr[ADDR_W-1:2]. Always -> WAIT.
//   - WAIT: capture mem_rdata. Load -> RSP with extended data; partial store -> WR with merged word.
//   - WR: mem_en=1, mem_we=1, mem_wdata=merged word (SW: wdata as-is). Always -> RSP.
//   - RSP: rsp_valid=1 for exactly one cycle, then -> IDLE. Next request is accepted the cycle after.
//  mem_* are combinational from state and latched regs. They are 0 in IDLE, WAIT and RSP.
//  Load extraction, lane = addr[1:0]:
//   - byte = rdata[8*lane+7 : 8*lane]
//   - half = rdata[16*addr[1]+15 : 16*addr[1]]
//   - B/H sign-extend; BU/HU zero-extend; W passes through.
//  Store merge: replace only the addressed byte or half of the read word with wdata[7:0] or wdata[15:0].
//  Latency, accept edge = cycle 0, rsp_valid high in cycle:
//   - error 1
//   - SW 2
//   - loads 3
//   - SB/SH 4
//  rsp_rdata and rsp_err hold their values from RSP until the next RSP. rsp_err=0 on success.
//  req_valid while busy is ignored (req_ready=0). Core must hold the request until accepted.
// TESTING
//  1. Reset: assert rst 2 cycles mid-SB (in WAIT).
//     -> mem_we never 1; req_ready=1 and rsp_valid=0 after release.
//  2. SW addr 0x08, wdata 0xDEADBEEF.
//     -> WR cycle 1: mem_addr=2, mem_wdata=0xDEADBEEF; rsp_valid cycle 2, rsp_err=0.
//  3. LB 0x0B on word 0xDEADBEEF -> rsp_rdata 0xFFFFFFDE cycle 3.
//     LBU 0x0B -> 0x000000DE. LHU 0x08 -> 0x0000BEEF. LH 0x0A -> 0xFFFFDEAD.
//  4. SB addr 0x09, wdata 0x12345677 on 0xDEADBEEF.
//     -> RD, WAIT, WR with mem_wdata=0xDEAD77EF; rsp_valid cycle 4.
//  5. SH 0x0A wdata 0x0000CAFE -> word 0xCAFEBEEF.
//     Then LW 0x08 -> 0xCAFEBEEF.
//  6. LW addr 0x0A -> rsp_err=1 cycle 1, mem_en never 1.
//     SH 0x05 -> err=1. LB size 011 -> err=1. SB size 100 -> err=1.
//     Back-to-back requests each accepted only when req_ready=1.

Source files
------------

// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit bridging the core data port to a word-only synchronous RAM.
// Sub-word stores are performed as read-modify-write; bad requests respond with an error.
module lsu_rmw_ctrl #(
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_t;

   state_t            state;
   logic              we_q;
   logic [2:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              req_err_c;

   // Illegal size or misaligned address, evaluated on the incoming request
   always_comb begin
      req_err_c = 1'b0;
      case (req_size)
         SZ_B:         req_err_c = 1'b0;
         SZ_H:         req_err_c = req_addr[0];
         SZ_W:         req_err_c = (req_addr[1:0] != 2'b00);
         SZ_BU:        req_err_c = req_we;
         SZ_HU:        req_err_c = req_we | req_addr[0];
         default:      req_err_c = 1'b1;
      endcase
   end

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] sz,
                                            input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         SZ_B:    load_ext = {{24{b[7]}}, b};
         SZ_H:    load_ext = {{16{h[15]}}, h};
         SZ_BU:   load_ext = {24'h0, b};
         SZ_HU:   load_ext = {16'h0, h};
         default: load_ext = w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [2:0] sz, input logic [1:0] lane);
      logic [31:0] m;
      m = w;
      if (sz[1:0] == 2'b00) begin
         case (lane)
            2'd0:    m[7:0]   = d[7:0];
            2'd1:    m[15:8]  = d[7:0];
            2'd2:    m[23:16] = d[7:0];
            default: m[31:24] = d[7:0];
         endcase
      end else if (sz[1:0] == 2'b01) begin
         if (lane[1]) m[31:16] = d[15:0];
         else         m[15:0]  = d[15:0];
      end else begin
         m = d;
      end
      return m;
   endfunction

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (req_err_c) begin
                     state     <= RSP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end else if (req_we && (req_size == SZ_W)) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: state <= WAIT;
            WAIT: begin
               if (we_q) begin
                  wdata_q <= store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                  state   <= WR;
               end else begin
                  rsp_rdata <= load_ext(mem_rdata, size_q, addr_q[1:0]);
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end
            end
            WR: begin
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RSP;
            end
            RSP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM strobes decode directly from the current state
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      case (state)
         RD: begin
            mem_en   = 1'b1;
            mem_addr = addr_q[ADDR_W-1:2];
         end
         WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q[ADDR_W-1:2];
            mem_wdata = wdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a behavioural synchronous word RAM.
module tb_lsu_rmw_ctrl;

   localparam int unsigned ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              ram_clr;
   logic [31:0]       ram [0:31];

   int checks = 0;
   int errors = 0;

   lsu_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 32; i++) ram[i] <= 32'h0;
         mem_rdata <= 32'h0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // Issue one request and watch the bus until the response (cycle 1 = first cycle after accept)
   task automatic do_req(input logic we, input logic [2:0] sz, input logic [6:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int en_cnt, output int wr_cyc,
                         output logic [4:0] wa, output logic [31:0] wdo);
      lat = -1; rd = 32'h0; er = 1'b0; en_cnt = 0; wr_cyc = -1; wa = 5'h0; wdo = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (mem_we) begin wr_cyc = c; wa = mem_addr; wdo = mem_wdata; end
         if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; break; end
      end
   endtask

   task automatic test_reset();
      int saw_we;
      rst = 1'b1; ram_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_size = 3'b000; req_addr = '0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; ram_clr = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if ({rsp_valid, rsp_err, mem_en, mem_we} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rsp_valid, rsp_err, mem_en, mem_we}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
      // SB to word 3, reset while waiting for the read word
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 7'h0C; req_wdata = 32'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL abort_rd_en got %b exp 1", mem_en); end
      @(negedge clk);
      saw_we = 0;
      rst = 1'b1;
      repeat (2) begin @(negedge clk); if (mem_we) saw_we++; end
      rst = 1'b0;
      repeat (3) begin @(negedge clk); if (mem_we || rsp_valid) saw_we++; end
      checks++; if (saw_we !== 0) begin errors++; $display("FAIL abort_no_write got %0d exp 0", saw_we); end
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
      checks++; if (ram[3] !== 32'h0) begin errors++; $display("FAIL abort_ram got %h exp 0", ram[3]); end
   endtask

   task automatic test_sw();
      int lat, en, wc; logic [31:0] rd, wdo; logic er; logic [4:0] wa;
      do_req(1'b1, 3'b010, 7'h08, 32'hDEADBEEF, lat, rd, er, en, wc, wa, wdo);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
      checks++; if (wc !== 1 || wa !== 5'd2 || wdo !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write got cyc %0d addr %0d data %h exp 1 2 deadbeef", wc, wa, wdo); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_rsp got err %b rdata %h exp 0 0", er, rd); end
      checks++; if (ram[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram got %h exp deadbeef", ram[2]); end
   endtask

   task automatic test_loads();
      int lat, en, wc; logic [31:0] rd, wdo; logic er; logic [4:0] wa;
      logic [2:0]  sz  [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
      logic [6:0]  ad  [5] = '{7'h0B, 7'h0B, 7'h08, 7'h0A, 7'h08};
      logic [31:0] exp [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000BEEF, 32'hFFFFDEAD, 32'hDEADBEEF};
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, sz[i], ad[i], 32'h0, lat, rd, er, en, wc, wa, wdo);
         checks++; if (lat !== 3 || er !== 1'b0 || wc !== -1) begin errors++; $display("FAIL load%0d_timing got lat %0d err %b wr %0d exp 3 0 -1", i, lat, er, wc); end
         checks++; if (rd !== exp[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, rd, exp[i]); end
      end
   endtask

   task automatic test_sub_store();
      int lat, en, wc; logic [31:0] rd, wdo; logic er; logic [4:0] wa;
      do_req(1'b1, 3'b000, 7'h09, 32'h12345677, lat, rd, er, en, wc, wa, wdo);
      checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL sb_latency got %0d err %b exp 4 0", lat, er); end
      checks++; if (wc !== 3 || wa !== 5'd2 || wdo !== 32'hDEAD77EF) begin errors++; $display("FAIL sb_merge got cyc %0d addr %0d data %h exp 3 2 dead77ef", wc, wa, wdo); end
      checks++; if (en !== 2) begin errors++; $display("FAIL sb_en_cycles got %0d exp 2", en); end
      do_req(1'b1, 3'b010, 7'h08, 32'hDEADBEEF, lat, rd, er, en, wc, wa, wdo);
      do_req(1'b1, 3'b001, 7'h0A, 32'h0000CAFE, lat, rd, er, en, wc, wa, wdo);
      checks++; if (lat !== 4 || wdo !== 32'hCAFEBEEF) begin errors++; $display("FAIL sh_merge got lat %0d data %h exp 4 cafebeef", lat, wdo); end
      do_req(1'b0, 3'b010, 7'h08, 32'h0, lat, rd, er, en, wc, wa, wdo);
      checks++; if (rd !== 32'hCAFEBEEF) begin errors++; $display("FAIL sh_readback got %h exp cafebeef", rd); end
   endtask

   task automatic test_errors();
      int lat, en, wc; logic [31:0] rd, wdo; logic er; logic [4:0] wa;
      logic       we [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] sz [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
      logic [6:0] ad [5] = '{7'h0A, 7'h05, 7'h08, 7'h08, 7'h03};
      for (int i = 0; i < 5; i++) begin
         do_req(we[i], sz[i], ad[i], 32'h55, lat, rd, er, en, wc, wa, wdo);
         checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err%0d_rsp got lat %0d err %b rdata %h exp 1 1 0", i, lat, er, rd); end
         checks++; if (en !== 0) begin errors++; $display("FAIL err%0d_no_mem got %0d exp 0", i, en); end
      end
      checks++; if (ram[2] !== 32'hCAFEBEEF) begin errors++; $display("FAIL err_ram got %h exp cafebeef", ram[2]); end
      @(negedge clk);
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", rsp_err); end
   endtask

   task automatic test_back_to_back();
      int rsp_cyc [2]; logic [31:0] rsp_dat [2]; int n, ready_cnt;
      n = 0; ready_cnt = 0; rsp_cyc = '{-1, -1}; rsp_dat = '{32'h0, 32'h0};
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 7'h08;
      @(posedge clk);
      for (int c = 1; c <= 12 && n < 2; c++) begin
         @(negedge clk);
         if (req_ready) ready_cnt++;
         if (rsp_valid) begin
            rsp_cyc[n] = c; rsp_dat[n] = rsp_rdata; n++;
            if (n == 1) begin req_size = 3'b000; req_addr = 7'h0B; end
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      checks++; if (rsp_cyc[0] !== 3 || rsp_dat[0] !== 32'hCAFEBEEF) begin errors++; $display("FAIL b2b_first got cyc %0d data %h exp 3 cafebeef", rsp_cyc[0], rsp_dat[0]); end
      checks++; if (rsp_cyc[1] !== 7 || rsp_dat[1] !== 32'hFFFFFFCA) begin errors++; $display("FAIL b2b_second got cyc %0d data %h exp 7 ffffffca", rsp_cyc[1], rsp_dat[1]); end
      checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL b2b_ready got %0d exp 1", ready_cnt); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_loads();
      test_sub_store();
      test_errors();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
